// File: rtl/jstk_spi_master.sv
// PmodJSTK SPI-mode-0 poller: 5-byte transaction every POLL_PERIOD, X/Y/buttons published atomically on valid.
// Define JSTK_AVG_EN to average each new X/Y sample with the previous published value.
module jstk_spi_master #(
  parameter int CLK_DIV     = 66,
  parameter int SS_SETUP    = 1500,
  parameter int BYTE_GAP    = 1000,
  parameter int POLL_PERIOD = 1000000
) (
  input  logic       clk,
  input  logic       clr_n,
  input  logic [1:0] led,
  input  logic       miso,
  output logic       sclk,
  output logic       ss_n,
  output logic       mosi,
  output logic [9:0] joy_x,
  output logic [9:0] joy_y,
  output logic [2:0] btn,
  output logic       valid,
  output logic       busy
);

  localparam int M1   = (CLK_DIV > SS_SETUP) ? CLK_DIV : SS_SETUP;
  localparam int M2   = (BYTE_GAP > POLL_PERIOD) ? BYTE_GAP : POLL_PERIOD;
  localparam int CMAX = (M1 > M2) ? M1 : M2;
  localparam int CW   = $clog2(CMAX + 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_SETUP = 3'd1;
  localparam logic [2:0] S_SHIFT = 3'd2;
  localparam logic [2:0] S_GAP   = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  logic [2:0]    state;
  logic [CW-1:0] cnt;
  logic [2:0]    bit_cnt;
  logic [2:0]    byte_idx;
  logic [7:0]    tx_sr;
  logic [7:0]    rx_sr;
  logic [9:0]    sh_x;
  logic [9:0]    sh_y;
  logic [2:0]    sh_btn;

`ifdef JSTK_AVG_EN
  logic [10:0] sum_x;
  logic [10:0] sum_y;
  assign sum_x = {1'b0, joy_x} + {1'b0, sh_x};
  assign sum_y = {1'b0, joy_y} + {1'b0, sh_y};
`endif

  assign mosi = tx_sr[7];
  assign busy = ~ss_n;

  always_ff @(posedge clk) begin
    if (!clr_n) begin
      state    <= S_IDLE;
      cnt      <= '0;
      bit_cnt  <= '0;
      byte_idx <= '0;
      tx_sr    <= '0;
      rx_sr    <= '0;
      sh_x     <= '0;
      sh_y     <= '0;
      sh_btn   <= '0;
      sclk     <= 1'b0;
      ss_n     <= 1'b1;
      valid    <= 1'b0;
      joy_x    <= 10'd512;
      joy_y    <= 10'd512;
      btn      <= 3'd0;
    end else begin
      valid <= 1'b0;
      case (state)
        S_IDLE: begin
          if (cnt == CW'(POLL_PERIOD - 1)) begin
            state    <= S_SETUP;
            cnt      <= '0;
            ss_n     <= 1'b0;
            byte_idx <= '0;
            bit_cnt  <= '0;
            tx_sr    <= {6'b100000, led};
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_SETUP: begin
          if (cnt == CW'(SS_SETUP - 1)) begin
            state <= S_SHIFT;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_SHIFT: begin
          if (cnt == CW'(CLK_DIV - 1)) begin
            cnt <= '0;
            if (!sclk) begin
              sclk  <= 1'b1;
              rx_sr <= {rx_sr[6:0], miso};
            end else begin
              // Falling edge: advance mosi; zeros shift in, so bytes 1..4 transmit 0x00.
              sclk    <= 1'b0;
              tx_sr   <= {tx_sr[6:0], 1'b0};
              bit_cnt <= bit_cnt + 1'b1;
              if (bit_cnt == 3'd7) begin
                case (byte_idx)
                  3'd0:    sh_x[7:0] <= rx_sr;
                  3'd1:    sh_x[9:8] <= rx_sr[1:0];
                  3'd2:    sh_y[7:0] <= rx_sr;
                  3'd3:    sh_y[9:8] <= rx_sr[1:0];
                  default: sh_btn    <= rx_sr[2:0];
                endcase
                state <= (byte_idx == 3'd4) ? S_DONE : S_GAP;
              end
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_GAP: begin
          if (cnt == CW'(BYTE_GAP - 1)) begin
            cnt      <= '0;
            byte_idx <= byte_idx + 1'b1;
            state    <= S_SHIFT;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_DONE: begin
          state <= S_IDLE;
          cnt   <= '0;
          ss_n  <= 1'b1;
          valid <= 1'b1;
          btn   <= sh_btn;
`ifdef JSTK_AVG_EN
          joy_x <= sum_x[10:1];
          joy_y <= sum_y[10:1];
`else
          joy_x <= sh_x;
          joy_y <= sh_y;
`endif
        end
        default: begin
          state <= S_IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_jstk_spi_master.sv
// Scoreboarded bench: a slave model serves randomized/directed bytes and a monitor compares published results.
module tb_jstk_spi_master;
  localparam int CLK_DIV     = 4;
  localparam int SS_SETUP    = 20;
  localparam int BYTE_GAP    = 10;
  localparam int POLL_PERIOD = 500;

  logic       clk   = 1'b0;
  logic       clr_n = 1'b0;
  logic [1:0] led   = 2'b00;
  logic       miso  = 1'b0;
  logic       sclk, ss_n, mosi, valid, busy;
  logic [9:0] joy_x, joy_y;
  logic [2:0] btn;

  jstk_spi_master #(
    .CLK_DIV(CLK_DIV), .SS_SETUP(SS_SETUP), .BYTE_GAP(BYTE_GAP), .POLL_PERIOD(POLL_PERIOD)
  ) dut (
    .clk(clk), .clr_n(clr_n), .led(led), .miso(miso), .sclk(sclk), .ss_n(ss_n),
    .mosi(mosi), .joy_x(joy_x), .joy_y(joy_y), .btn(btn), .valid(valid), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  typedef struct { int x; int y; int b; } exp_t;
  exp_t        exp_q[$];
  logic [39:0] plan_q[$];

  int          model_x = 512;
  int          model_y = 512;
  logic [39:0] cur;
  logic [39:0] mosi_cap;
  logic [7:0]  exp_b0;
  int          rises = 0;
  int          busy_len = 0;
  int          first_rise = 0;
  int          vld_seen = 0;
  logic        in_txn = 1'b0;
  logic        prev_ss = 1'b1;
  logic        prev_sclk = 1'b0;

  // Slave model and monitor, sampling on the falling clk edge.
  always @(negedge clk) begin
    if (!clr_n) begin
      in_txn  = 1'b0;
      miso    = 1'b0;
      model_x = 512;
      model_y = 512;
      exp_q.delete();
    end else begin
      if (prev_ss && !ss_n) begin
        logic [63:0] r;
        int b0, b1, b2, b3, b4, nx, ny;
        exp_t e;
        r = {$urandom(), $urandom()};
        cur = (plan_q.size() > 0) ? plan_q.pop_front() : r[39:0];
        b0 = int'(cur[39:32]); b1 = int'(cur[31:24]); b2 = int'(cur[23:16]);
        b3 = int'(cur[15:8]);  b4 = int'(cur[7:0]);
        nx = b0 + 256 * (b1 % 4);
        ny = b2 + 256 * (b3 % 4);
`ifdef JSTK_AVG_EN
        model_x = (model_x + nx) / 2;
        model_y = (model_y + ny) / 2;
`else
        model_x = nx;
        model_y = ny;
`endif
        e.x = model_x; e.y = model_y; e.b = b4 % 8;
        exp_q.push_back(e);
        exp_b0     = 8'h80 + {6'd0, led};
        in_txn     = 1'b1;
        rises      = 0;
        busy_len   = 0;
        first_rise = -1;
        mosi_cap   = '0;
        miso       = cur[39];
      end
      if (in_txn) begin
        if (busy) busy_len++;
        if (!prev_sclk && sclk) begin
          if (rises == 0) first_rise = busy_len - 1;
          mosi_cap = {mosi_cap[38:0], mosi};
          rises++;
        end
        if (prev_sclk && !sclk && rises < 40) miso = cur[39 - rises];
        if (!prev_ss && ss_n) begin
          check("busy_cycles", busy_len, SS_SETUP + 5 * 16 * CLK_DIV + 4 * BYTE_GAP + 1);
          check("sclk_rises", rises, 40);
          check("first_rise_offset", first_rise, SS_SETUP + CLK_DIV);
          check("mosi_byte0", int'(mosi_cap[39:32]), int'(exp_b0));
          check("mosi_bytes1_4_zero", int'(mosi_cap[31:0] != 32'd0), 0);
          in_txn = 1'b0;
        end
      end
      if (valid) begin
        vld_seen++;
        if (exp_q.size() == 0) begin
          check("valid_expected", 0, 1);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("joy_x", int'(joy_x), e.x);
          check("joy_y", int'(joy_y), e.y);
          check("btn", int'(btn), e.b);
        end
      end
    end
    prev_ss   = ss_n;
    prev_sclk = sclk;
  end

  task automatic wait_valid();
    int start;
    int n;
    start = vld_seen;
    n = 0;
    while (vld_seen == start && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check("valid_arrived", int'(vld_seen != start), 1);
  endtask

  initial begin
    int n;
    int vc;

    led = 2'b11;
    plan_q.push_back(40'h34_02_C8_01_05);
    clr_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_joy_x", int'(joy_x), 512);
    check("rst_joy_y", int'(joy_y), 512);
    check("rst_btn", int'(btn), 0);
    check("rst_ss_n", int'(ss_n), 1);
    check("rst_sclk", int'(sclk), 0);
    check("rst_valid", int'(valid), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_mosi", int'(mosi), 0);

    clr_n = 1'b1;
    n = 0;
    while (ss_n && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check("poll_to_ss_fall", n, POLL_PERIOD);

    wait_valid();
`ifndef JSTK_AVG_EN
    check("basic_x", int'(joy_x), 564);
    check("basic_y", int'(joy_y), 456);
    check("basic_btn", int'(btn), 5);
`endif

    led = 2'b01;
    plan_q.push_back(40'hFF_FF_00_FC_F8);
    wait_valid();
`ifndef JSTK_AVG_EN
    check("extreme_x", int'(joy_x), 1023);
    check("extreme_y", int'(joy_y), 0);
    check("extreme_btn", int'(btn), 0);
`endif

    repeat (6) begin
      led = 2'($urandom_range(0, 3));
      wait_valid();
    end

    // Abort during byte 2 of a transaction that would publish X=100.
    plan_q.push_back(40'h64_00_20_01_02);
    n = 0;
    while (!(in_txn && rises >= 16) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check("reached_byte2", int'(in_txn && rises >= 16 && rises < 24), 1);
    vc = vld_seen;
    clr_n = 1'b0;
    @(negedge clk);
    check("abort_ss_n", int'(ss_n), 1);
    check("abort_busy", int'(busy), 0);
    repeat (2) @(negedge clk);
    check("abort_joy_x", int'(joy_x), 512);
    check("abort_no_valid", vld_seen - vc, 0);
    clr_n = 1'b1;

    plan_q.push_back(40'hFF_03_00_02_01);
    plan_q.push_back(40'hFF_03_00_02_01);
    wait_valid();
`ifdef JSTK_AVG_EN
    check("avg_first_x", int'(joy_x), 767);
`else
    check("post_abort_x", int'(joy_x), 1023);
`endif
    wait_valid();
`ifdef JSTK_AVG_EN
    check("avg_second_x", int'(joy_x), 895);
`else
    check("second_x", int'(joy_x), 1023);
`endif

    led = 2'($urandom_range(0, 3));
    wait_valid();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
